// File: rtl/chien_search.sv
// Chien search over GF(2^6)/GF(2^8)/GF(2^10): evaluates up to two
// error-locator polynomials at alpha^j for j = 0..n-1, one j per cycle,
// and reports error positions, root counts and uncorrectable flags.

// Field multiplier over the field selected by i_code (00/11: GF(2^6),
// 01: GF(2^8), 10: GF(2^10)). Operands are LSB-aligned field elements.
module gf_mult (
  input  logic [1:0] i_code,
  input  logic [9:0] i_a,
  input  logic [9:0] i_b,
  output logic [9:0] o_p
);
  logic [3:0] top;
  logic [9:0] mask;
  logic [9:0] red;
  logic [9:0] p;
  logic       hi;

  // MSB-first shift-and-add with reduction by the primitive polynomial
  always_comb begin
    top  = 4'd5;
    mask = 10'h03F;
    red  = 10'h003;
    case (i_code)
      2'b01: begin top = 4'd7; mask = 10'h0FF; red = 10'h01D; end
      2'b10: begin top = 4'd9; mask = 10'h3FF; red = 10'h009; end
      default: ;
    endcase
    p  = '0;
    hi = 1'b0;
    for (int i = 9; i >= 0; i--) begin
      hi = p[top];
      p  = {p[8:0], 1'b0} & mask;
      if (hi)      p = p ^ red;
      if (i_b[i])  p = p ^ i_a;
    end
    o_p = p;
  end
endmodule

module chien_search (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_code,
  input  logic       i_mode,
  input  logic       i_start,
  input  logic [9:0] i_sigma1_0,
  input  logic [9:0] i_sigma1_1,
  input  logic [9:0] i_sigma1_2,
  input  logic [9:0] i_sigma1_3,
  input  logic [9:0] i_sigma1_4,
  input  logic [9:0] i_sigma2_0,
  input  logic [9:0] i_sigma2_1,
  input  logic [9:0] i_sigma2_2,
  output logic       o_ready,
  output logic       o_loc1_valid,
  output logic       o_loc2_valid,
  output logic [9:0] o_loc1,
  output logic [9:0] o_loc2,
  output logic       o_done,
  output logic       o_fail1,
  output logic       o_fail2,
  output logic [2:0] o_cnt1,
  output logic [2:0] o_cnt2
);
  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      code_q, code_d;
  logic            dual_q, dual_d;
  logic [4:0][9:0] r1_q, r1_d, r1_nx;
  logic [2:0][9:0] r2_q, r2_d, r2_nx;
  logic [2:0]      d1_q, d1_d, d2_q, d2_d;
  logic [2:0]      cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic [9:0]      j_q, j_d;
  logic [9:0]      loc1_q, loc1_d, loc2_q, loc2_d;
  logic            v1_q, v1_d, v2_q, v2_d;
  logic            done_q, done_d;
  logic            fail1_q, fail1_d, fail2_q, fail2_d;

  // request decode (only meaningful in the cycle i_start is accepted)
  logic [1:0]      in_code;
  logic [9:0]      in_mask;
  logic [4:0][9:0] in_s1;
  logic [2:0][9:0] in_s2;
  logic            in_dual;
  logic [2:0]      in_d1, in_d2, in_t;
  logic            in_srch;

  // search-cycle evaluation
  logic [9:0] n_m1, pos, s1_sum, s2_sum;
  logic [2:0] t_cur;
  logic       hit1, hit2;

  // degree = highest index holding a nonzero coefficient
  function automatic logic [2:0] deg5(input logic [4:0][9:0] c);
    deg5 = 3'd0;
    for (int k = 1; k < 5; k++)
      if (c[k] != 10'd0) deg5 = 3'(k);
  endfunction

  function automatic logic fail_f(input logic s0z, input logic [2:0] d,
                                  input logic [2:0] cnt, input logic [2:0] t);
    fail_f = s0z || (d > t) || (cnt != d);
  endfunction

  // term multipliers: r_k advances by alpha^k each search cycle
  for (genvar k = 0; k < 5; k++) begin : g_t1
    gf_mult u_mul (.i_code(code_q), .i_a(r1_q[k]), .i_b(10'(1 << k)), .o_p(r1_nx[k]));
  end
  for (genvar k = 0; k < 3; k++) begin : g_t2
    gf_mult u_mul (.i_code(code_q), .i_a(r2_q[k]), .i_b(10'(1 << k)), .o_p(r2_nx[k]));
  end

  // normalise the incoming request: reserved code folds to GF(2^6),
  // coefficients masked to the field and to the polynomial's index range
  always_comb begin
    in_code = (i_code == 2'b11) ? 2'b00 : i_code;
    case (in_code)
      2'b01:   in_mask = 10'h0FF;
      2'b10:   in_mask = 10'h3FF;
      default: in_mask = 10'h03F;
    endcase
    in_dual  = i_mode && (in_code != 2'b10);
    in_t     = (in_code == 2'b10) ? 3'd4 : 3'd2;
    in_s1[0] = i_sigma1_0 & in_mask;
    in_s1[1] = i_sigma1_1 & in_mask;
    in_s1[2] = i_sigma1_2 & in_mask;
    in_s1[3] = (in_code == 2'b10) ? (i_sigma1_3 & in_mask) : 10'd0;
    in_s1[4] = (in_code == 2'b10) ? (i_sigma1_4 & in_mask) : 10'd0;
    in_s2[0] = in_dual ? (i_sigma2_0 & in_mask) : 10'd0;
    in_s2[1] = in_dual ? (i_sigma2_1 & in_mask) : 10'd0;
    in_s2[2] = in_dual ? (i_sigma2_2 & in_mask) : 10'd0;
    in_d1    = deg5(in_s1);
    in_d2    = deg5({20'd0, in_s2});
    // a search is only worthwhile if some polynomial can actually have roots
    in_srch  = ((in_s1[0] != 10'd0) && (in_d1 != 3'd0)) ||
               (in_dual && (in_s2[0] != 10'd0) && (in_d2 != 3'd0));
  end

  // evaluate sigma(alpha^j) for the current j and map j to a position
  always_comb begin
    case (code_q)
      2'b01:   n_m1 = 10'd254;
      2'b10:   n_m1 = 10'd1022;
      default: n_m1 = 10'd62;
    endcase
    t_cur  = (code_q == 2'b10) ? 3'd4 : 3'd2;
    s1_sum = r1_q[0] ^ r1_q[1] ^ r1_q[2] ^ r1_q[3] ^ r1_q[4];
    s2_sum = r2_q[0] ^ r2_q[1] ^ r2_q[2];
    // r_0 never changes, so it still holds sigma_0 during the search
    hit1   = (s1_sum == 10'd0) && (r1_q[0] != 10'd0);
    hit2   = dual_q && (s2_sum == 10'd0) && (r2_q[0] != 10'd0);
    pos    = (j_q == 10'd0) ? 10'd0 : (n_m1 + 10'd1 - j_q);
  end

  // FSM next-state and datapath updates
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    dual_d  = dual_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    cnt1_d  = cnt1_q;
    cnt2_d  = cnt2_q;
    j_d     = j_q;
    loc1_d  = loc1_q;
    loc2_d  = loc2_q;
    v1_d    = 1'b0;
    v2_d    = 1'b0;
    done_d  = 1'b0;
    fail1_d = 1'b0;
    fail2_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          code_d = in_code;
          dual_d = in_dual;
          r1_d   = in_s1;
          r2_d   = in_s2;
          d1_d   = in_d1;
          d2_d   = in_d2;
          cnt1_d = 3'd0;
          cnt2_d = 3'd0;
          j_d    = 10'd0;
          if (!in_dual) loc2_d = 10'd0;
          if (in_srch) begin
            state_d = S_SEARCH;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            fail1_d = fail_f(in_s1[0] == 10'd0, in_d1, 3'd0, in_t);
            fail2_d = in_dual && fail_f(in_s2[0] == 10'd0, in_d2, 3'd0, in_t);
          end
        end
      end
      S_SEARCH: begin
        r1_d = r1_nx;
        r2_d = r2_nx;
        if (hit1) begin
          v1_d   = 1'b1;
          loc1_d = pos;
          cnt1_d = (cnt1_q == 3'd7) ? 3'd7 : cnt1_q + 3'd1;
        end
        if (hit2) begin
          v2_d   = 1'b1;
          loc2_d = pos;
          cnt2_d = (cnt2_q == 3'd7) ? 3'd7 : cnt2_q + 3'd1;
        end
        if (j_q == n_m1) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          fail1_d = fail_f(r1_q[0] == 10'd0, d1_q, cnt1_d, t_cur);
          fail2_d = dual_q && fail_f(r2_q[0] == 10'd0, d2_q, cnt2_d, t_cur);
        end else begin
          j_d = j_q + 10'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      code_q  <= 2'b00;
      dual_q  <= 1'b0;
      r1_q    <= '0;
      r2_q    <= '0;
      d1_q    <= 3'd0;
      d2_q    <= 3'd0;
      cnt1_q  <= 3'd0;
      cnt2_q  <= 3'd0;
      j_q     <= 10'd0;
      loc1_q  <= 10'd0;
      loc2_q  <= 10'd0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      done_q  <= 1'b0;
      fail1_q <= 1'b0;
      fail2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      dual_q  <= dual_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
      j_q     <= j_d;
      loc1_q  <= loc1_d;
      loc2_q  <= loc2_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      done_q  <= done_d;
      fail1_q <= fail1_d;
      fail2_q <= fail2_d;
    end
  end

  assign o_ready      = (state_q == S_IDLE);
  assign o_loc1_valid = v1_q;
  assign o_loc2_valid = v2_q;
  assign o_loc1       = loc1_q;
  assign o_loc2       = loc2_q;
  assign o_done       = done_q;
  assign o_fail1      = fail1_q;
  assign o_fail2      = fail2_q;
  assign o_cnt1       = cnt1_q;
  assign o_cnt2       = cnt2_q;
endmodule

// File: tb/tb_chien_search.sv
// Directed bench for chien_search: table of hand-computed searches plus
// sequences for start-during-DONE and reset-mid-search.
module tb_chien_search;
  logic       i_clk = 1'b0;
  logic       i_rst_n, i_mode, i_start;
  logic [1:0] i_code;
  logic [9:0] i_sigma1_0, i_sigma1_1, i_sigma1_2, i_sigma1_3, i_sigma1_4;
  logic [9:0] i_sigma2_0, i_sigma2_1, i_sigma2_2;
  logic       o_ready, o_loc1_valid, o_loc2_valid, o_done, o_fail1, o_fail2;
  logic [9:0] o_loc1, o_loc2;
  logic [2:0] o_cnt1, o_cnt2;

  chien_search dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_code(i_code), .i_mode(i_mode), .i_start(i_start),
    .i_sigma1_0(i_sigma1_0), .i_sigma1_1(i_sigma1_1), .i_sigma1_2(i_sigma1_2),
    .i_sigma1_3(i_sigma1_3), .i_sigma1_4(i_sigma1_4),
    .i_sigma2_0(i_sigma2_0), .i_sigma2_1(i_sigma2_1), .i_sigma2_2(i_sigma2_2),
    .o_ready(o_ready), .o_loc1_valid(o_loc1_valid), .o_loc2_valid(o_loc2_valid),
    .o_loc1(o_loc1), .o_loc2(o_loc2), .o_done(o_done), .o_fail1(o_fail1),
    .o_fail2(o_fail2), .o_cnt1(o_cnt1), .o_cnt2(o_cnt2)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0] code;
    logic       mode;
    int s1[5];
    int s2[3];
    int lat, np1, f1, l1, np2, l2, c1, fl1, c2, fl2;
  } vec_t;

  int checks = 0;
  int failures = 0;
  vec_t tv[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, $signed(act), $signed(exp));
    end
  endtask

  function automatic vec_t mk(input logic [1:0] c, input logic m,
      input int a0, a1, a2, a3, a4, b0, b1, b2,
      input int lat, np1, f1, l1, np2, l2, c1, fl1, c2, fl2);
    vec_t r;
    r.code = c; r.mode = m;
    r.s1[0] = a0; r.s1[1] = a1; r.s1[2] = a2; r.s1[3] = a3; r.s1[4] = a4;
    r.s2[0] = b0; r.s2[1] = b1; r.s2[2] = b2;
    r.lat = lat; r.np1 = np1; r.f1 = f1; r.l1 = l1; r.np2 = np2; r.l2 = l2;
    r.c1 = c1; r.fl1 = fl1; r.c2 = c2; r.fl2 = fl2;
    return r;
  endfunction

  task automatic drive(input vec_t v);
    i_code = v.code; i_mode = v.mode;
    i_sigma1_0 = 10'(v.s1[0]); i_sigma1_1 = 10'(v.s1[1]); i_sigma1_2 = 10'(v.s1[2]);
    i_sigma1_3 = 10'(v.s1[3]); i_sigma1_4 = 10'(v.s1[4]);
    i_sigma2_0 = 10'(v.s2[0]); i_sigma2_1 = 10'(v.s2[1]); i_sigma2_2 = 10'(v.s2[2]);
  endtask

  task automatic garbage();
    i_code = 2'b01; i_mode = 1'b1;
    i_sigma1_0 = 10'h3A5; i_sigma1_1 = 10'h001; i_sigma1_2 = 10'h2C3;
    i_sigma1_3 = 10'h155; i_sigma1_4 = 10'h0F0;
    i_sigma2_0 = 10'h001; i_sigma2_1 = 10'h001; i_sigma2_2 = 10'h000;
  endtask

  // lat=1 is the first cycle after the accepting edge
  task automatic run_vec(input int idx, input vec_t v);
    int lat, np1, f1, l1, np2, l2, c1, fl1, c2, fl2, loc2_end;
    bit seen;
    @(negedge i_clk);
    chk($sformatf("v%0d ready_before", idx), {31'd0, o_ready}, 1);
    drive(v);
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    garbage();
    lat = 1; np1 = 0; f1 = -1; l1 = -1; np2 = 0; l2 = -1; seen = 0;
    c1 = 0; fl1 = 0; c2 = 0; fl2 = 0; loc2_end = 0;
    while (!seen && lat <= 1100) begin
      if (o_loc1_valid) begin np1++; if (f1 < 0) f1 = int'(o_loc1); l1 = int'(o_loc1); end
      if (o_loc2_valid) begin np2++; l2 = int'(o_loc2); end
      if (o_done) begin
        seen = 1;
        c1 = int'(o_cnt1); fl1 = int'(o_fail1); c2 = int'(o_cnt2); fl2 = int'(o_fail2);
        loc2_end = int'(o_loc2);
      end else begin
        i_start = (lat == 5);   // stray request mid-search must be ignored
        @(posedge i_clk); #1;
        lat++;
      end
    end
    i_start = 1'b0;
    chk($sformatf("v%0d done_seen", idx), {31'd0, seen}, 1);
    chk($sformatf("v%0d latency", idx), lat, v.lat);
    chk($sformatf("v%0d loc1_pulses", idx), np1, v.np1);
    chk($sformatf("v%0d loc1_first", idx), f1, v.f1);
    chk($sformatf("v%0d loc1_last", idx), l1, v.l1);
    chk($sformatf("v%0d loc2_pulses", idx), np2, v.np2);
    chk($sformatf("v%0d loc2_last", idx), l2, v.l2);
    chk($sformatf("v%0d loc2_hold", idx), loc2_end, (v.np2 > 0) ? v.l2 : 0);
    chk($sformatf("v%0d cnt1", idx), c1, v.c1);
    chk($sformatf("v%0d fail1", idx), fl1, v.fl1);
    chk($sformatf("v%0d cnt2", idx), c2, v.c2);
    chk($sformatf("v%0d fail2", idx), fl2, v.fl2);
    @(posedge i_clk); #1;
    chk($sformatf("v%0d done_one_cycle", idx), {31'd0, o_done}, 0);
    chk($sformatf("v%0d ready_after", idx), {31'd0, o_ready}, 1);
  endtask

  initial begin
    int ndone;
    //          code  md  s1 0..4            s2 0..2   lat  np1 f1  l1  np2 l2 c1 fl1 c2 fl2
    tv[0]  = mk(2'b00, 0, 1, 1, 0, 0, 0,     0, 0, 0,  64,  1, 0,   0,   0, -1, 1, 0, 0, 0);
    tv[1]  = mk(2'b10, 0, 1, 3, 2, 0, 0,     0, 0, 0,  1024,2, 0,   1,   0, -1, 2, 0, 0, 0);
    tv[2]  = mk(2'b01, 0, 1, 0, 1, 0, 0,     0, 0, 0,  256, 1, 0,   0,   0, -1, 1, 1, 0, 0);
    tv[3]  = mk(2'b00, 1, 1, 2, 0, 0, 0,     0, 5, 1,  64,  1, 1,   1,   0, -1, 1, 0, 0, 1);
    tv[4]  = mk(2'b00, 0, 7, 0, 0, 0, 0,     0, 0, 0,  1,   0, -1, -1,   0, -1, 0, 0, 0, 0);
    tv[5]  = mk(2'b11, 0, 1, 1, 0, 0, 0,     0, 0, 0,  64,  1, 0,   0,   0, -1, 1, 0, 0, 0);
    tv[6]  = mk(2'b01, 1, 1, 1, 0, 0, 0,     1, 2, 0,  256, 1, 0,   0,   1,  1, 1, 0, 1, 0);
    tv[7]  = mk(2'b10, 1, 1, 1, 0, 0, 0,     1, 2, 0,  1024,1, 0,   0,   0, -1, 1, 0, 0, 0);
    tv[8]  = mk(2'b00, 0, 0, 1, 1, 0, 0,     0, 0, 0,  1,   0, -1, -1,   0, -1, 0, 1, 0, 0);
    tv[9]  = mk(2'b00, 0, 1, 1, 1, 0, 0,     0, 0, 0,  64,  2, 42, 21,   0, -1, 2, 0, 0, 0);
    tv[10] = mk(2'b10, 0, 1, 0, 0, 0, 1,     0, 0, 0,  1024,1, 0,   0,   0, -1, 1, 1, 0, 0);
    tv[11] = mk(2'b00, 0, 1, 1, 0, 5, 5,     0, 0, 0,  64,  1, 0,   0,   0, -1, 1, 0, 0, 0);
    tv[12] = mk(2'b01, 0, 1, 1, 1, 0, 0,     0, 0, 0,  256, 2, 170, 85,  0, -1, 2, 0, 0, 0);
    tv[13] = mk(2'b01, 1, 0, 0, 0, 0, 0,     3, 0, 0,  1,   0, -1, -1,   0, -1, 0, 1, 0, 0);

    // reset state
    i_rst_n = 1'b0; i_start = 1'b0; garbage();
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst ready", {31'd0, o_ready}, 1);
    chk("rst outputs", {10'd0, o_loc1_valid, o_loc2_valid, o_loc1, o_loc2, o_done,
                        o_fail1, o_fail2, o_cnt1, o_cnt2}, 0);
    i_rst_n = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(i, tv[i]);

    // start presented during the DONE cycle is dropped
    @(negedge i_clk);
    drive(tv[4]); i_start = 1'b1;
    @(posedge i_clk); #1;
    chk("dstart done", {31'd0, o_done}, 1);
    drive(tv[0]); i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 4; k++) begin
      if (!o_ready || o_done) ndone++;
      @(posedge i_clk); #1;
    end
    chk("dstart ignored", ndone, 0);

    // reset at j=100 of a GF(2^8) search: root at j=85 already counted
    @(negedge i_clk);
    drive(tv[12]); i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (100) @(posedge i_clk);
    #1;
    chk("midrst cnt_before", {29'd0, o_cnt1}, 1);
    chk("midrst busy", {31'd0, o_ready}, 0);
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    chk("midrst ready", {31'd0, o_ready}, 1);
    chk("midrst outputs", {10'd0, o_loc1_valid, o_loc2_valid, o_loc1, o_loc2, o_done,
                           o_fail1, o_fail2, o_cnt1, o_cnt2}, 0);
    ndone = 0;
    for (int k = 0; k < 300; k++) begin
      if (o_done || !o_ready) ndone++;
      @(posedge i_clk); #1;
    end
    chk("midrst no_done", ndone, 0);
    run_vec(100, tv[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/chien_search.md
CHIEN_SEARCH -- requirements
Module: chien_search

Interface
REQ-001 i_clk  input  1  clock; all state updates on rising edge.
REQ-002 i_rst_n  input  1  reset, synchronous, active-low.
REQ-003 i_code  input  2  field select: 00 GF(2^6) n=63 t=2; 01 GF(2^8) n=255 t=2; 10 GF(2^10) n=1023 t=4; 11 reserved, treated as 00.
REQ-004 i_mode  input  1  1 = two independent polynomials (sigma1, sigma2) searched in parallel; ignored when i_code=10.
REQ-005 i_start  input  1  one-cycle request; coefficients valid this cycle.
REQ-006 i_sigma1_0..i_sigma1_4  input  10 each  sigma1 coefficients, index = power of x; elements LSB-aligned, unused upper bits zero.
REQ-007 i_sigma2_0..i_sigma2_2  input  10 each  sigma2 coefficients.
REQ-008 o_ready  output  1  high only in IDLE.
REQ-009 o_loc1_valid, o_loc2_valid  output  1 each  one-cycle pulse per root found.
REQ-010 o_loc1, o_loc2  output  10 each  error position p, 0..n-1.
REQ-011 o_done  output  1  one-cycle completion pulse.
REQ-012 o_fail1, o_fail2  output  1 each  uncorrectable flag, valid while o_done=1.
REQ-013 o_cnt1, o_cnt2  output  3 each  roots found, valid while o_done=1.

Function
REQ-014 Primitive polynomials SHALL be x^6+x+1, x^8+x^4+x^3+x^2+1, x^10+x^3+1; alpha = 10'd2; field multiplies SHALL use the team gf_mult with the latched code.
REQ-015 FSM SHALL have states IDLE, SEARCH, DONE; reset enters IDLE.
REQ-016 IDLE: i_start=1 SHALL latch i_code, i_mode and all coefficients, clear counts/flags, and set j=0.
REQ-017 Degree d = highest index with nonzero coefficient (sigma1 indices 0..4 for code 10, 0..2 otherwise; sigma2 always 0..2).
REQ-018 Polynomial with sigma_0=0 SHALL be marked fail with count 0 and SHALL emit no locations.
REQ-019 If every active polynomial has d=0 or sigma_0=0, IDLE SHALL go directly to DONE; otherwise to SEARCH.
REQ-020 SEARCH: term registers r_k initialised to sigma_k, updated r_k <= r_k*alpha^k each cycle; cycle with counter j evaluates S(j)=XOR of r_k = sigma(alpha^j).
REQ-021 S(j)=0 on a searchable polynomial SHALL, at the next edge, assert o_locX_valid for one cycle with o_locX = (n-j) mod n, and increment o_cntX (saturating at 7).
REQ-022 Counter j SHALL run 0..n-1; after j=n-1 FSM SHALL enter DONE (one SEARCH cycle per j, n cycles total).
REQ-023 DONE lasts exactly one cycle with o_done=1, then returns to IDLE; the final location pulse (from j=n-1) coincides with o_done.
REQ-024 o_failX=1 iff sigma_0=0, d>t, or final count != d; sigma2 outputs/flags SHALL be zero when dual mode inactive.
REQ-025 i_start while not in IDLE SHALL be ignored; inputs other than at accepted i_start SHALL not affect operation.
REQ-026 o_locX SHALL hold last value between pulses; all pulses registered.

Reset
REQ-027 i_rst_n=0 at any edge, including mid-SEARCH, SHALL force IDLE, o_ready=1 next cycle, all other outputs 0, counters and term registers 0.
REQ-028 Search interrupted by reset SHALL produce no o_done.

Verification
REQ-029 code=00, sigma1=(1,1,0) -> o_loc1_valid once, o_loc1=0, 63 SEARCH cycles, o_done with o_cnt1=1, o_fail1=0.
REQ-030 code=10, sigma1=(1,3,2,0,0) -> locations 0 and 1 (j=0, j=1022), o_cnt1=2, o_fail1=0, o_done 1024 cycles after start accepted.
REQ-031 code=01, sigma1=(1,0,1) (double root) -> one location p=0, o_cnt1=1, o_fail1=1.
REQ-032 code=00, i_mode=1, sigma1=(1,2,0), sigma2=(0,5,1) -> o_loc1=1 once; no o_loc2 pulses; o_fail2=1, o_cnt2=0.
REQ-033 sigma1=(7,0,0) single poly -> o_done one cycle after start, o_cnt1=0, o_fail1=0; i_start during that DONE cycle ignored.
REQ-034 Reset asserted at j=100 of a code-01 search -> IDLE, no o_done, o_ready=1 next cycle; new start then completes normally.
